// File: rtl/systolic_matmul_tile_if.sv
// Bundle of the handshake and data buses of systolic_matmul_tile.
// The tile drives it through the slave modport; the client uses master.
interface systolic_matmul_tile_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 8
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic                             start;
  logic [K_WIDTH-1:0]               k_len;
  logic                             busy;
  logic                             in_valid;
  logic                             in_ready;
  logic [N-1:0][DATA_WIDTH-1:0]     a_col;
  logic [N-1:0][DATA_WIDTH-1:0]     b_row;
  logic                             out_valid;
  logic                             out_ready;
  logic [N-1:0][ACC_WIDTH-1:0]      out_data;
  logic [RW-1:0]                    out_row;
  logic                             out_last;

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output busy, in_ready, out_valid, out_data, out_row, out_last
  );

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  busy, in_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/systolic_matmul_tile.sv
// N x N output-stationary systolic matrix-multiply tile.
// A columns enter from the left, B rows from the top, each lane skewed by its
// index; every PE accumulates its own C element, then rows are read out.
// Optional build macro SYSTOLIC_SATURATE_EN: accumulators clamp instead of wrap.
module systolic_matmul_tile #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  systolic_matmul_tile_if.slave  bus
);
  localparam int RW  = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = $clog2(2 * N) + 1;
  localparam int CW  = (K_WIDTH > DCW) ? K_WIDTH : DCW;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic               clear;
  logic               step;
  logic               load_act;

  logic [DATA_WIDTH-1:0] a_feed [N];
  logic [DATA_WIDTH-1:0] b_feed [N];
  logic [DATA_WIDTH-1:0] a_pe   [N][N];
  logic [DATA_WIDTH-1:0] b_pe   [N][N];
  logic [ACC_WIDTH-1:0]  c_pe   [N][N];
  logic [N-1:0][ACC_WIDTH-1:0] out_data_w;

  assign load_act = (state_q == LOAD);

  // Control state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: beat/drain/row counting, array clear and step enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    k_d     = k_q;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          k_d     = bus.k_len;
          cnt_d   = '0;
          row_d   = '0;
          state_d = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          step = 1'b1;
          if (cnt_q == CW'(k_q - 1'b1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        step = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Input skew: lane gi is delayed by gi array steps; zeros enter outside LOAD.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_WIDTH-1:0] a_in, b_in;
    assign a_in = load_act ? bus.a_col[gi] : '0;
    assign b_in = load_act ? bus.b_row[gi] : '0;
    if (gi == 0) begin : g_direct
      assign a_feed[gi] = a_in;
      assign b_feed[gi] = b_in;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] a_sk_q [gi];
      logic [DATA_WIDTH-1:0] b_sk_q [gi];
      // Shift the delay line only on array steps so bubbles freeze it.
      always_ff @(posedge clock) begin
        if (!reset || clear) begin
          for (int i = 0; i < gi; i++) begin
            a_sk_q[i] <= '0;
            b_sk_q[i] <= '0;
          end
        end else if (step) begin
          a_sk_q[0] <= a_in;
          b_sk_q[0] <= b_in;
          for (int i = 1; i < gi; i++) begin
            a_sk_q[i] <= a_sk_q[i-1];
            b_sk_q[i] <= b_sk_q[i-1];
          end
        end
      end
      assign a_feed[gi] = a_sk_q[gi-1];
      assign b_feed[gi] = b_sk_q[gi-1];
    end
  end

  // Processing element grid.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic signed [DATA_WIDTH-1:0]   a_q, b_q, a_src, b_src;
      logic signed [ACC_WIDTH-1:0]    acc_q, acc_d, prod_ext;
      logic signed [2*DATA_WIDTH-1:0] prod;

      if (gj == 0) begin : g_a_edge
        assign a_src = a_feed[gi];
      end else begin : g_a_inner
        assign a_src = a_pe[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_src = b_feed[gj];
      end else begin : g_b_inner
        assign b_src = b_pe[gi-1][gj];
      end

      // Full-width signed product, then sign-extended or truncated to the accumulator.
      assign prod     = a_q * b_q;
      assign prod_ext = ACC_WIDTH'(prod);

`ifdef SYSTOLIC_SATURATE_EN
      logic signed [ACC_WIDTH:0] sum_w;
      // Accumulate with one guard bit and clamp on signed overflow.
      always_comb begin
        sum_w = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
        if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
          acc_d = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
          acc_d = sum_w[ACC_WIDTH-1:0];
        end
      end
`else
      assign acc_d = acc_q + prod_ext;
`endif

      // Pass A right and B down, accumulating the product of the held pair.
      always_ff @(posedge clock) begin
        if (!reset || clear) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (step) begin
          a_q   <= a_src;
          b_q   <= b_src;
          acc_q <= acc_d;
        end
      end

      assign a_pe[gi][gj] = a_q;
      assign b_pe[gi][gj] = b_q;
      assign c_pe[gi][gj] = acc_q;
    end
  end

  // Result row selection; zero outside OUTPUT.
  always_comb begin
    out_data_w = '0;
    if (state_q == OUTPUT) begin
      for (int c = 0; c < N; c++) out_data_w[c] = c_pe[row_q][c];
    end
  end

  assign bus.out_data  = out_data_w;
  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = load_act;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_row   = row_q;
  assign bus.out_last  = (state_q == OUTPUT) && (row_q == ROW_LAST);
endmodule

// File: tb/tb_systolic_matmul_tile.sv
// Directed testbench for systolic_matmul_tile: a 4x4/32-bit tile driven from a
// vector table, plus a 2x2/8-bit/16-bit tile for identity latency and overflow.
module tb_systolic_matmul_tile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_matmul_tile_if #(.N(4), .DATA_WIDTH(32), .ACC_WIDTH(32), .K_WIDTH(8)) bi();
  systolic_matmul_tile_if #(.N(2), .DATA_WIDTH(8),  .ACC_WIDTH(16), .K_WIDTH(8)) si();

  systolic_matmul_tile #(.N(4), .DATA_WIDTH(32), .ACC_WIDTH(32), .K_WIDTH(8)) dut_big (
    .clock(clk), .reset(rst_n), .bus(bi)
  );
  systolic_matmul_tile #(.N(2), .DATA_WIDTH(8), .ACC_WIDTH(16), .K_WIDTH(8)) dut_small (
    .clock(clk), .reset(rst_n), .bus(si)
  );

  typedef struct {
    int k;
    bit bub;      // toggle in_valid every cycle
    bit bp;       // hold out_ready low 5 cycles on row 1
    bit ds;       // pulse start during LOAD
    int as;
    int bs;
    int bo;
    int exp_c00;  // hand-computed C[0][0]
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int A_m [4][8];
  int B_m [8][4];
  int exp_m [4][4];
  vec_t vecs [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // A[r][t] = as*(5r+3t-7); B[t][c] = bs*(2t-3c+4)+bo; reference product over k beats.
  task automatic fill_mats(input vec_t v);
    for (int r = 0; r < 4; r++)
      for (int t = 0; t < 8; t++) A_m[r][t] = v.as * (r * 5 + t * 3 - 7);
    for (int t = 0; t < 8; t++)
      for (int c = 0; c < 4; c++) B_m[t][c] = v.bs * (t * 2 - c * 3 + 4) + v.bo;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        exp_m[r][c] = 0;
        for (int t = 0; t < v.k; t++) exp_m[r][c] += A_m[r][t] * B_m[t][c];
      end
  endtask

  task automatic run_big(input int k, input bit bub, input bit bp, input bit ds,
                         output int got [4][4]);
    int beat, cyc, rows, stall;
    logic [127:0] held;
    logic [1:0] held_row;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) got[r][c] = 32'h7ead_beef;
    held = '0;
    held_row = '0;
    @(negedge clk);
    bi.start = 1'b1;
    bi.k_len = 8'(k);
    @(negedge clk);
    bi.start = 1'b0;
    chk("busy_after_start", bi.busy, 1);
    beat = 0;
    cyc = 0;
    while (beat < k && cyc < 100) begin
      if (ds && cyc == 1) begin
        bi.start = 1'b1;
        bi.k_len = 8'd7;
      end else begin
        bi.start = 1'b0;
      end
      if (bub && cyc[0]) begin
        bi.in_valid = 1'b0;
      end else begin
        bi.in_valid = 1'b1;
        for (int r = 0; r < 4; r++) bi.a_col[r] = A_m[r][beat];
        for (int c = 0; c < 4; c++) bi.b_row[c] = B_m[beat][c];
      end
      if (bi.in_valid && bi.in_ready) beat++;
      cyc++;
      @(negedge clk);
    end
    bi.in_valid = 1'b0;
    bi.start = 1'b0;
    chk("load_beats", beat, k);
    rows = 0;
    stall = 0;
    cyc = 0;
    while (rows < 4 && cyc < 200) begin
      bi.out_ready = !(bp && rows == 1 && stall < 5);
      if (bi.out_valid) begin
        if (!bi.out_ready) begin
          if (stall == 0) begin
            held = bi.out_data;
            held_row = bi.out_row;
          end else begin
            chk("bp_data_stable", bi.out_data == held, 1);
            chk("bp_row_stable", bi.out_row, held_row);
          end
          stall++;
        end else begin
          chk("out_row", bi.out_row, rows);
          chk("out_last", bi.out_last, (rows == 3));
          for (int c = 0; c < 4; c++) got[rows][c] = int'(bi.out_data[c]);
          rows++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    bi.out_ready = 1'b1;
    chk("rows_delivered", rows, 4);
    if (bp) chk("bp_stall_cycles", stall, 5);
    chk("idle_busy", bi.busy, 0);
    chk("idle_out_valid", bi.out_valid, 0);
  endtask

  task automatic do_vec(input vec_t v);
    int got [4][4];
    fill_mats(v);
    run_big(v.k, v.bub, v.bp, v.ds, got);
    chk("c00_hand", got[0][0], v.exp_c00);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) chk($sformatf("c[%0d][%0d]", r, c), got[r][c], exp_m[r][c]);
    $display("vector k=%0d bub=%0d bp=%0d ds=%0d done, %0d/%0d so far",
             v.k, v.bub, v.bp, v.ds, n_pass, n_total);
  endtask

  // Small tile: identity A with B=[[1,2],[3,4]] when ident, else every element = val.
  task automatic run_small(input int k, input bit ident, input int val,
                           output int got [2][2], output int lat);
    int beat, rows, cyc;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) got[r][c] = 12345;
    @(negedge clk);
    si.start = 1'b1;
    si.k_len = 8'(k);
    @(negedge clk);
    si.start = 1'b0;
    lat = 1;
    beat = 0;
    while (beat < k && lat < 50) begin
      si.in_valid = 1'b1;
      for (int r = 0; r < 2; r++) si.a_col[r] = ident ? 8'(r == beat) : 8'(val);
      for (int c = 0; c < 2; c++) si.b_row[c] = ident ? 8'(beat * 2 + c + 1) : 8'(val);
      if (si.in_ready) beat++;
      @(negedge clk);
      lat++;
    end
    si.in_valid = 1'b0;
    while (!si.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rows = 0;
    cyc = 0;
    while (rows < 2 && cyc < 50) begin
      if (si.out_valid) begin
        chk("small_out_row", si.out_row, rows);
        chk("small_out_last", si.out_last, (rows == 1));
        for (int c = 0; c < 2; c++) got[rows][c] = int'($signed(si.out_data[c]));
        rows++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("small_rows", rows, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int sg [2][2];
    int lat;
    int ovf_exp;
    vec_t rv;
    vecs[0] = '{4, 1'b0, 1'b0, 1'b0,  1,  1,  0,   -40};
    vecs[1] = '{4, 1'b1, 1'b0, 1'b0,  1,  1,  0,   -40};
    vecs[2] = '{4, 1'b0, 1'b1, 1'b0,  2, -1,  3,    20};
    vecs[3] = '{3, 1'b0, 1'b0, 1'b1, -1,  2,  1,   132};
    vecs[4] = '{0, 1'b0, 1'b0, 1'b0,  1,  1,  0,     0};
    vecs[5] = '{8, 1'b1, 1'b1, 1'b0, -3,  1, -5, -1260};
    rv      = '{2, 1'b0, 1'b0, 1'b0,  1,  1,  0,   -52};

    bi.start = 1'b0; bi.k_len = '0; bi.in_valid = 1'b0; bi.a_col = '0; bi.b_row = '0;
    bi.out_ready = 1'b1;
    si.start = 1'b0; si.k_len = '0; si.in_valid = 1'b0; si.a_col = '0; si.b_row = '0;
    si.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", bi.busy, 0);
    chk("rst_in_ready", bi.in_ready, 0);
    chk("rst_out_valid", bi.out_valid, 0);
    chk("rst_out_row", bi.out_row, 0);
    chk("rst_out_last", bi.out_last, 0);
    chk("rst_out_data", bi.out_data == '0, 1);
    rst_n = 1'b1;

    // Identity with latency measurement on the 2x2 tile.
    run_small(2, 1'b1, 0, sg, lat);
    chk("ident_latency", lat, 6);
    chk("ident_c00", sg[0][0], 1);
    chk("ident_c01", sg[0][1], 2);
    chk("ident_c10", sg[1][0], 3);
    chk("ident_c11", sg[1][1], 4);
    $display("identity done, %0d/%0d so far", n_pass, n_total);

    // Overflow: 4 * 127 * 127 = 64516 exceeds the 16-bit accumulator.
`ifdef SYSTOLIC_SATURATE_EN
    ovf_exp = 32767;
`else
    ovf_exp = -1020;
`endif
    run_small(4, 1'b0, 127, sg, lat);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) chk($sformatf("ovf_c%0d%0d", r, c), sg[r][c], ovf_exp);
    $display("overflow done, %0d/%0d so far", n_pass, n_total);

    for (int i = 0; i < 6; i++) do_vec(vecs[i]);

    // Reset pulse in the middle of DRAIN, then a normal k_len=2 run.
    fill_mats(rv);
    @(negedge clk);
    bi.start = 1'b1;
    bi.k_len = 8'd2;
    @(negedge clk);
    bi.start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      bi.in_valid = 1'b1;
      for (int r = 0; r < 4; r++) bi.a_col[r] = A_m[r][t];
      for (int c = 0; c < 4; c++) bi.b_row[c] = B_m[t][c];
      @(negedge clk);
    end
    bi.in_valid = 1'b0;
    @(negedge clk);
    chk("drain_busy", bi.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", bi.busy, 0);
    chk("abort_out_valid", bi.out_valid, 0);
    chk("abort_in_ready", bi.in_ready, 0);
    do_vec(rv);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
